cpu_hold_arbiter: RTL and testbench
===================================

CPU_HOLD_ARBITER -- requirements
Module: cpu_hold_arbiter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 24000000, clk_sys frequency in Hz.
REQ-002 SHALL have parameter DIM_SECONDS, default 10, paused time before dimming.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, cycles between halt and RAM grant.
REQ-004 SHALL have port clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port vblank  in  1  video vertical blank, synchronous to clk_sys.
REQ-007 SHALL have port user_button  in  1  level input; each rising edge toggles user pause.
REQ-008 SHALL have port osd_open  in  1  OSD visible.
REQ-009 SHALL have port osd_pause_en  in  1  OSD-open pause option enable.
REQ-010 SHALL have port dim_en  in  1  dim-after-timeout option enable.
REQ-011 SHALL have port hs_req  in  1  hiscore engine requests CPU halt and work-RAM access.
REQ-012 SHALL have port pause_cpu  out  1  CPU halt to game core.
REQ-013 SHALL have port hs_grant  out  1  hiscore engine may drive work-RAM port.
REQ-014 SHALL have port dim_video  out  1  video dim request.
REQ-015 SHALL have port user_paused  out  1  current user-pause latch state.

Function
REQ-016 SHALL compute hold_req = user_paused | (osd_open & osd_pause_en) | hs_req.
REQ-017 SHALL detect user_button and vblank rising edges from one registered copy each.
REQ-018 SHALL use FSM states RUN, WAIT_VBL, SETTLE and HELD.
REQ-019 RUN: pause_cpu=0; on hold_req=1 SHALL move to WAIT_VBL next cycle.
REQ-020 WAIT_VBL: on a vblank rising edge with hold_req=1, SHALL move to SETTLE and assert pause_cpu from the next cycle.
REQ-021 WAIT_VBL: if hold_req drops before the vblank edge, SHALL return to RUN with pause_cpu never asserted.
REQ-022 SETTLE: SHALL count SETTLE_CYCLES cycles with pause_cpu=1, then move to HELD; hold_req=0 during SETTLE still completes SETTLE first.
REQ-023 HELD: hs_grant SHALL be registered (state==HELD & hs_req), so grant rises one cycle after entry or request and falls one cycle after hs_req drops.
REQ-024 HELD: when hold_req=0 and hs_grant=0, SHALL move to RUN; pause_cpu deasserts the same edge.
REQ-025 hs_grant SHALL never be 1 while pause_cpu=0.
REQ-026 user_button edge SHALL toggle user_paused in any state; simultaneous edge and hs_req release leaves the FSM in HELD.
REQ-027 Dim counter SHALL be wide enough to hold CLK_HZ*DIM_SECONDS.
REQ-028 Dim counter SHALL increment each cycle while pause_cpu=1 and (user_paused | osd_open&osd_pause_en), saturating at CLK_HZ*DIM_SECONDS.
REQ-029 Dim counter SHALL clear to 0 whenever that condition is false.
REQ-030 dim_video SHALL be 1 iff dim_en=1 and the dim counter is saturated.
REQ-031 Pauses caused only by hs_req SHALL never dim.

Reset
REQ-032 reset_n=0 SHALL immediately force state RUN, pause_cpu=0, hs_grant=0, dim_video=0, user_paused=0, dim counter=0, and both edge registers to 0.
REQ-033 Reset mid-HELD SHALL drop hs_grant and pause_cpu the same instant; a hiscore transfer in progress is abandoned.

Structure
REQ-034 Package cpu_hold_pkg SHALL hold the FSM state enum and a function giving the dim counter width.
REQ-035 The dim counter SHALL be one sub-module, dim_timer (inputs: count enable, dim_en; output: dim_video).

Verification (CLK_HZ=100, DIM_SECONDS=1, SETTLE_CYCLES=4)
REQ-036 Scenario: pulse user_button, vblank rises 10 cycles later -> pause_cpu=1 on cycle 11, never earlier.
REQ-037 Scenario: hs_req=1 from RUN, with vblank edge -> pause_cpu then hs_grant exactly 4+1 cycles later; drop hs_req -> hs_grant 0 next cycle, pause_cpu 0 the cycle after.
REQ-038 Scenario: osd_open=1, osd_pause_en=1, held paused -> dim_video=1 after 100 counting cycles; dim_en=0 -> dim_video=0; close OSD -> counter 0, dim_video 0.
REQ-039 Scenario: hs_req held 500 cycles alone -> dim_video stays 0.
REQ-040 Scenario: hold_req drops inside WAIT_VBL -> back to RUN, pause_cpu never 1.
REQ-041 Scenario: reset_n low while HELD with grant -> all outputs 0 asynchronously; after release, FSM in RUN and user_paused=0.

Source files
------------

// File: rtl/cpu_hold_pkg.sv
// Shared types and sizing helpers for the CPU hold arbiter.
package cpu_hold_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_VBL = 2'd1,
      ST_SETTLE   = 2'd2,
      ST_HELD     = 2'd3
   } hold_state_t;

   // Bits needed to hold values 0..limit inclusive.
   function automatic int dim_width(input longint limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/cpu_hold_arbiter_dim_timer.sv
// Saturating paused-time counter; requests video dimming once the limit is reached.
module dim_timer #(
   parameter longint LIMIT = 240000000,
   parameter int     WIDTH = 28
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic count_en,
   input  logic dim_en,
   output logic dim_video
);

   localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (!count_en) begin
         count <= '0;
      end else if (count != LIMIT_V) begin
         count <= count + WIDTH'(1);
      end
   end

   assign dim_video = dim_en & (count == LIMIT_V);

endmodule

// File: rtl/cpu_hold_arbiter.sv
// Halts the game CPU at vblank for user/OSD pause or hiscore RAM access.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | CPU running, no hold pending
// WAIT_VBL | hold requested, waiting for vblank rising edge
// SETTLE   | CPU halted, letting the bus settle before any RAM grant
// HELD     | CPU halted; hiscore engine granted while it requests
module cpu_hold_arbiter
   import cpu_hold_pkg::*;
#(
   parameter int CLK_HZ        = 24000000,
   parameter int DIM_SECONDS   = 10,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic vblank,
   input  logic user_button,
   input  logic osd_open,
   input  logic osd_pause_en,
   input  logic dim_en,
   input  logic hs_req,
   output logic pause_cpu,
   output logic hs_grant,
   output logic dim_video,
   output logic user_paused
);

   localparam longint DIM_LIMIT = longint'(CLK_HZ) * longint'(DIM_SECONDS);
   localparam int     DIM_W     = dim_width(DIM_LIMIT);
   localparam int     SETTLE_W  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   hold_state_t         state;
   hold_state_t         state_nxt;
   logic                button_q;
   logic                vblank_q;
   logic                button_rise;
   logic                vblank_rise;
   logic                osd_hold;
   logic                hold_req;
   logic                settle_load;
   logic [SETTLE_W-1:0] settle_cnt;

   assign button_rise = user_button & ~button_q;
   assign vblank_rise = vblank & ~vblank_q;
   assign osd_hold    = osd_open & osd_pause_en;
   assign hold_req    = user_paused | osd_hold | hs_req;
   assign pause_cpu   = (state == ST_SETTLE) | (state == ST_HELD);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         button_q    <= 1'b0;
         vblank_q    <= 1'b0;
         user_paused <= 1'b0;
         hs_grant    <= 1'b0;
         state       <= ST_RUN;
      end else begin
         button_q    <= user_button;
         vblank_q    <= vblank;
         user_paused <= user_paused ^ button_rise;
         hs_grant    <= (state == ST_HELD) & hs_req;
         state       <= state_nxt;
      end
   end

   // Down-counter: loaded on SETTLE entry, HELD follows its terminal count.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         settle_cnt <= '0;
      end else if (settle_load) begin
         settle_cnt <= SETTLE_LOAD;
      end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
         settle_cnt <= settle_cnt - SETTLE_W'(1);
      end
   end

   always_comb begin
      state_nxt   = state;
      settle_load = 1'b0;
      case (state)
         ST_RUN: begin
            if (hold_req) state_nxt = ST_WAIT_VBL;
         end
         ST_WAIT_VBL: begin
            if (!hold_req) begin
               state_nxt = ST_RUN;
            end else if (vblank_rise) begin
               state_nxt   = ST_SETTLE;
               settle_load = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt == '0) state_nxt = ST_HELD;
         end
         ST_HELD: begin
            // A button edge this cycle re-pauses; stay halted rather than bounce through RUN.
            if (!hold_req && !hs_grant && !button_rise) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   dim_timer #(
      .LIMIT (DIM_LIMIT),
      .WIDTH (DIM_W)
   ) u_dim_timer (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .count_en  (pause_cpu & (user_paused | osd_hold)),
      .dim_en    (dim_en),
      .dim_video (dim_video)
   );

endmodule

// File: tb/tb_cpu_hold_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, random run vs reference model.
module tb_cpu_hold_arbiter;

   localparam int DIM_MAX = 100;
   localparam int SETTLE  = 4;

   logic clk_sys = 1'b0;
   logic reset_n;
   logic vblank, user_button, osd_open, osd_pause_en, dim_en, hs_req;
   logic pause_cpu, hs_grant, dim_video, user_paused;

   int checks   = 0;
   int failures = 0;

   always #5 clk_sys = ~clk_sys;

   cpu_hold_arbiter #(
      .CLK_HZ        (100),
      .DIM_SECONDS   (1),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .vblank       (vblank),
      .user_button  (user_button),
      .osd_open     (osd_open),
      .osd_pause_en (osd_pause_en),
      .dim_en       (dim_en),
      .hs_req       (hs_req),
      .pause_cpu    (pause_cpu),
      .hs_grant     (hs_grant),
      .dim_video    (dim_video),
      .user_paused  (user_paused)
   );

   // Reference model: halted/waiting flags, settle cycles left, paused-time count.
   bit m_halted, m_waiting, m_grant, m_user, m_btn_prev, m_vbl_prev;
   int m_settle, m_dim;

   task automatic model_reset();
      m_halted = 0; m_waiting = 0; m_grant = 0; m_user = 0;
      m_btn_prev = 0; m_vbl_prev = 0; m_settle = 0; m_dim = 0;
   endtask

   task automatic model_step();
      bit brise, vrise, user_hold, hold, held;
      brise     = user_button && !m_btn_prev;
      vrise     = vblank && !m_vbl_prev;
      user_hold = m_user || (osd_open && osd_pause_en);
      hold      = user_hold || hs_req;
      held      = m_halted && (m_settle == 0);
      if (m_halted && user_hold) m_dim = (m_dim < DIM_MAX) ? m_dim + 1 : DIM_MAX;
      else                       m_dim = 0;
      if (!m_halted) begin
         if (!m_waiting)  m_waiting = hold;
         else if (!hold)  m_waiting = 0;
         else if (vrise) begin
            m_waiting = 0; m_halted = 1; m_settle = SETTLE;
         end
      end else if (m_settle > 0) begin
         m_settle--;
      end else if (!hold && !m_grant && !brise) begin
         m_halted = 0;
      end
      m_grant    = held && hs_req;
      m_user     = m_user ^ brise;
      m_btn_prev = user_button;
      m_vbl_prev = vblank;
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_sys);
      #1;
      check("model_pause", pause_cpu, m_halted);
      check("model_grant", hs_grant, m_grant);
      check("model_user",  user_paused, m_user);
      check("model_dim",   dim_video, dim_en && (m_dim == DIM_MAX));
   endtask

   task automatic zero_inputs();
      vblank = 0; user_button = 0; osd_open = 0; osd_pause_en = 0; dim_en = 0; hs_req = 0;
   endtask

   task automatic do_reset(input string name);
      #2;
      reset_n = 1'b0;
      #1;
      check({name, "_pause"}, pause_cpu, 1'b0);
      check({name, "_grant"}, hs_grant, 1'b0);
      check({name, "_dim"},   dim_video, 1'b0);
      check({name, "_user"},  user_paused, 1'b0);
      zero_inputs();
      model_reset();
      repeat (2) @(posedge clk_sys);
      #4;
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [5:0] stim;  // {btn, vbl, osd, osd_en, dim_en, hs}
      logic [2:0] exp;   // {pause, grant, user}
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t mk(input logic [5:0] s, input logic [2:0] e);
      vec_t v;
      v.stim = s;
      v.exp  = e;
      return v;
   endfunction

   initial begin
      bit seen;
      int budget;

      vecs[0]  = mk(6'b000001, 3'b000);  vecs[1]  = mk(6'b000001, 3'b000);
      vecs[2]  = mk(6'b010001, 3'b100);  vecs[3]  = mk(6'b010001, 3'b100);
      vecs[4]  = mk(6'b000001, 3'b100);  vecs[5]  = mk(6'b000001, 3'b100);
      vecs[6]  = mk(6'b000001, 3'b100);  vecs[7]  = mk(6'b000001, 3'b110);
      vecs[8]  = mk(6'b000001, 3'b110);  vecs[9]  = mk(6'b000000, 3'b100);
      vecs[10] = mk(6'b000000, 3'b000);  vecs[11] = mk(6'b000000, 3'b000);
      vecs[12] = mk(6'b100000, 3'b001);  vecs[13] = mk(6'b100000, 3'b001);
      vecs[14] = mk(6'b000000, 3'b001);  vecs[15] = mk(6'b010000, 3'b101);
      vecs[16] = mk(6'b010000, 3'b101);  vecs[17] = mk(6'b000000, 3'b101);
      vecs[18] = mk(6'b000000, 3'b101);  vecs[19] = mk(6'b000000, 3'b101);
      vecs[20] = mk(6'b000000, 3'b101);  vecs[21] = mk(6'b100000, 3'b100);
      vecs[22] = mk(6'b100000, 3'b000);  vecs[23] = mk(6'b000000, 3'b000);

      zero_inputs();
      reset_n = 1'b0;
      model_reset();
      #1;
      check("reset_pause", pause_cpu, 1'b0);
      check("reset_grant", hs_grant, 1'b0);
      check("reset_dim",   dim_video, 1'b0);
      check("reset_user",  user_paused, 1'b0);
      #11;
      reset_n = 1'b1;

      // Vector table: hiscore hold/grant/release, then user pause with simultaneous unpause.
      for (int i = 0; i < 24; i++) begin
         {user_button, vblank, osd_open, osd_pause_en, dim_en, hs_req} = vecs[i].stim;
         tick();
         check($sformatf("vec%0d_pause", i), pause_cpu,   vecs[i].exp[2]);
         check($sformatf("vec%0d_grant", i), hs_grant,    vecs[i].exp[1]);
         check($sformatf("vec%0d_user", i),  user_paused, vecs[i].exp[0]);
      end

      // Button pulse, vblank rises 10 cycles later: halt appears only after that edge.
      zero_inputs();
      tick();
      user_button = 1; tick();
      user_button = 0;
      seen = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (pause_cpu) seen = 1;
      end
      check("vbl_delay_no_early_pause", seen, 1'b0);
      vblank = 1; tick();
      check("vbl_delay_pause", pause_cpu, 1'b1);
      vblank = 0;
      repeat (6) tick();
      user_button = 1; tick();
      user_button = 0;
      budget = 0;
      while (pause_cpu && budget < 10) begin tick(); budget++; end
      check("user_unpause_release", pause_cpu, 1'b0);

      // Hold withdrawn while waiting for vblank: CPU never halts.
      osd_open = 1; osd_pause_en = 1;
      seen = 0;
      repeat (3) begin tick(); if (pause_cpu) seen = 1; end
      osd_open = 0; tick(); if (pause_cpu) seen = 1;
      vblank = 1;
      repeat (3) begin tick(); if (pause_cpu) seen = 1; end
      vblank = 0; tick(); if (pause_cpu) seen = 1;
      check("wait_drop_no_pause", seen, 1'b0);

      // OSD pause dims after exactly DIM_MAX counting cycles.
      osd_open = 1; osd_pause_en = 1; dim_en = 1;
      tick();
      vblank = 1;
      budget = 0;
      do begin tick(); budget++; end while (!pause_cpu && budget < 20);
      check("dim_pause_reached", pause_cpu, 1'b1);
      vblank = 0;
      repeat (DIM_MAX - 1) tick();
      check("dim_before_limit", dim_video, 1'b0);
      tick();
      check("dim_at_limit", dim_video, 1'b1);
      dim_en = 0; #1;
      check("dim_disabled", dim_video, 1'b0);
      dim_en = 1; #1;
      check("dim_reenabled", dim_video, 1'b1);
      osd_open = 0; tick();
      check("dim_osd_closed", dim_video, 1'b0);
      check("osd_closed_release", pause_cpu, 1'b0);
      tick();
      check("dim_stays_clear", dim_video, 1'b0);

      // Long hiscore-only hold never dims; then reset mid-grant.
      hs_req = 1; dim_en = 1; tick();
      vblank = 1; tick(); vblank = 0;
      seen = 0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (dim_video) seen = 1;
      end
      check("hs_only_no_dim", seen, 1'b0);
      check("hs_long_grant", hs_grant, 1'b1);
      do_reset("reset_held");
      repeat (3) tick();
      check("post_reset_pause", pause_cpu, 1'b0);
      check("post_reset_user",  user_paused, 1'b0);
      check("post_reset_grant", hs_grant, 1'b0);

      // Random run against the reference model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19)  == 0) vblank       = ~vblank;
         if ($urandom_range(0, 29)  == 0) user_button  = ~user_button;
         if ($urandom_range(0, 149) == 0) osd_open     = ~osd_open;
         if ($urandom_range(0, 299) == 0) osd_pause_en = ~osd_pause_en;
         if ($urandom_range(0, 199) == 0) dim_en       = ~dim_en;
         if ($urandom_range(0, 59)  == 0) hs_req       = ~hs_req;
         tick();
         if (hs_grant && !pause_cpu) check("grant_implies_pause", pause_cpu, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
